// File: rtl/leitor_display.sv
// leitor_display -- reads back a two-digit multiplexed 7-segment bus and
// reconstructs the displayed value 0..63.
//
// Each {sel_digito, segmentos} pattern must stay unchanged for ESTAVEL edges
// before it is accepted. The tens digit is captured first and the units digit
// second. A good read updates valor and pulses valido. A bad read pulses erro
// instead. Bad reads are illegal patterns, sums above 63 and units timeouts.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   segmentos     {g,f,e,d,c,b,a}, bit 0 = a
//   sel_digito    1 = tens digit on the bus, 0 = units digit
//   valor         last successfully decoded value
//   valido        1-cycle pulse when valor updates
//   erro          1-cycle pulse on any rejected read
//   cont_erros    saturating error count (only with LEITOR_DISPLAY_CONT_ERROS_EN)
//
// Optional feature macro: LEITOR_DISPLAY_CONT_ERROS_EN
module leitor_display #(
  parameter int ESTAVEL     = 4,
  parameter int TIMEOUT     = 64,
  parameter int ATIVO_BAIXO = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] segmentos,
  input  logic       sel_digito,
  output logic [5:0] valor,
  output logic       valido,
`ifdef LEITOR_DISPLAY_CONT_ERROS_EN
  output logic       erro,
  output logic [7:0] cont_erros
`else
  output logic       erro
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {ESPERA_DEZ, ESPERA_UNI} estado_t;

  estado_t       estado, estado_n;
  logic [7:0]    amostra;
  logic [7:0]    cnt;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [2:0]    dez, dez_n;
  logic [5:0]    valor_n;
  logic          valido_n, erro_n;

  logic [7:0] entrada;
  logic [6:0] seg;
  logic       aceita;
  logic       ok, branco, ok_dez;
  logic [3:0] dig;
  logic [6:0] soma;

  assign entrada = {sel_digito, segmentos};
  assign seg     = (ATIVO_BAIXO != 0) ? ~segmentos : segmentos;
  // Fires only on the ESTAVEL-1 -> ESTAVEL step, so a held pattern is taken once.
  assign aceita  = (entrada == amostra) && (cnt == 8'(ESTAVEL - 1));

  always_comb begin
    ok  = 1'b1;
    dig = 4'd0;
    case (seg)
      7'h3F: dig = 4'd0;
      7'h06: dig = 4'd1;
      7'h5B: dig = 4'd2;
      7'h4F: dig = 4'd3;
      7'h66: dig = 4'd4;
      7'h6D: dig = 4'd5;
      7'h7D: dig = 4'd6;
      7'h07: dig = 4'd7;
      7'h7F: dig = 4'd8;
      7'h6F: dig = 4'd9;
      default: ok = 1'b0;
    endcase
  end

  // A blank tens digit means a leading zero. A blank units digit is an error.
  assign branco = (seg == 7'h00);
  assign ok_dez = branco || (ok && dig <= 4'd6);
  assign soma   = 7'(dez) * 7'd10 + 7'(dig);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amostra <= '0;
      cnt     <= '0;
    end else begin
      amostra <= entrada;
      if (entrada == amostra) begin
        if (cnt != 8'(ESTAVEL)) cnt <= cnt + 8'd1;
      end else begin
        cnt <= '0;
      end
    end
  end

  always_comb begin
    estado_n = estado;
    dez_n    = dez;
    tcnt_n   = tcnt;
    valor_n  = valor;
    valido_n = 1'b0;
    erro_n   = 1'b0;
    case (estado)
      ESPERA_DEZ: begin
        if (aceita && sel_digito) begin
          if (ok_dez) begin
            dez_n    = branco ? 3'd0 : dig[2:0];
            tcnt_n   = '0;
            estado_n = ESPERA_UNI;
          end else begin
            erro_n = 1'b1;
          end
        end
      end
      ESPERA_UNI: begin
        tcnt_n = tcnt + 1'b1;
        if (aceita) begin
          if (sel_digito) begin
            // A new tens digit replaces the old one and restarts the timeout.
            if (ok_dez) begin
              dez_n  = branco ? 3'd0 : dig[2:0];
              tcnt_n = '0;
            end else begin
              erro_n   = 1'b1;
              estado_n = ESPERA_DEZ;
            end
          end else begin
            estado_n = ESPERA_DEZ;
            if (ok && soma <= 7'd63) begin
              valor_n  = soma[5:0];
              valido_n = 1'b1;
            end else begin
              erro_n = 1'b1;
            end
          end
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          erro_n   = 1'b1;
          estado_n = ESPERA_DEZ;
        end
      end
      default: estado_n = ESPERA_DEZ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= ESPERA_DEZ;
      dez    <= '0;
      tcnt   <= '0;
      valor  <= '0;
      valido <= 1'b0;
      erro   <= 1'b0;
    end else begin
      estado <= estado_n;
      dez    <= dez_n;
      tcnt   <= tcnt_n;
      valor  <= valor_n;
      valido <= valido_n;
      erro   <= erro_n;
    end
  end

`ifdef LEITOR_DISPLAY_CONT_ERROS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           cont_erros <= '0;
    else if (erro_n && cont_erros != 8'hFF) cont_erros <= cont_erros + 8'd1;
  end
`endif

endmodule

// File: tb/tb_leitor_display.sv
// Scoreboard bench for leitor_display. Stimulus pushes the expected pulse
// (valido with value, or erro with held value) into a queue. A monitor per
// DUT pops and compares whenever the DUT pulses. dut0 uses active-high
// segments and dut1 uses active-low segments.
module tb_leitor_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg0 = '0, seg1 = '0;
  logic       sel0 = 1'b0, sel1 = 1'b0;
  logic [5:0] valor0, valor1;
  logic       valido0, valido1, erro0, erro1;
`ifdef LEITOR_DISPLAY_CONT_ERROS_EN
  logic [7:0] cont0, cont1;
`endif

  typedef struct packed {
    logic       e;
    logic [5:0] v;
  } ev_t;

  ev_t        q0[$], q1[$];
  logic [5:0] exp_valor0 = '0, exp_valor1 = '0;
  int         exp_errs0 = 0;
  int         total = 0, passed = 0;

  leitor_display dut0 (
    .clk(clk), .rst_n(rst_n), .segmentos(seg0), .sel_digito(sel0),
    .valor(valor0), .valido(valido0), .erro(erro0)
`ifdef LEITOR_DISPLAY_CONT_ERROS_EN
    , .cont_erros(cont0)
`endif
  );

  leitor_display #(.ATIVO_BAIXO(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .segmentos(seg1), .sel_digito(sel1),
    .valor(valor1), .valido(valido1), .erro(erro1)
`ifdef LEITOR_DISPLAY_CONT_ERROS_EN
    , .cont_erros(cont1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  always @(negedge clk) if (rst_n && (valido0 || erro0)) begin
    ev_t e;
    chk("dut0 exclusive pulses", int'(valido0 && erro0), 0);
    chk("dut0 pulse expected", int'(q0.size() > 0), 1);
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("dut0 erro kind", int'(erro0), int'(e.e));
      chk("dut0 valor", int'(valor0), int'(e.v));
    end
  end

  always @(negedge clk) if (rst_n && (valido1 || erro1)) begin
    ev_t e;
    chk("dut1 exclusive pulses", int'(valido1 && erro1), 0);
    chk("dut1 pulse expected", int'(q1.size() > 0), 1);
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("dut1 erro kind", int'(erro1), int'(e.e));
      chk("dut1 valor", int'(valor1), int'(e.v));
    end
  end

  task automatic ok0(input logic [5:0] v);
    q0.push_back({1'b0, v});
    exp_valor0 = v;
  endtask

  task automatic err0();
    q0.push_back({1'b1, exp_valor0});
    exp_errs0++;
  endtask

  // Drive one DUT's bus for n cycles (inputs change 1 time unit after posedge).
  task automatic drive(input bit u, input logic s, input logic [6:0] g, input int n);
    if (u) begin sel1 = s; seg1 = g; end
    else   begin sel0 = s; seg0 = g; end
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [6:0] t, input logic [6:0] un);
    drive(0, 1'b1, t, 6);
    drive(0, 1'b0, un, 6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("reset valor", int'(valor0), 0);
    chk("reset valido", int'(valido0), 0);
    chk("reset erro", int'(erro0), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 1'b0, 7'h00, 3);

    // 34, then 63, overflow 69 -> erro (valor holds 63), blank tens -> 0
    ok0(34); rd(7'h4F, 7'h66);
    ok0(63); rd(7'h7D, 7'h4F);
    err0();  rd(7'h7D, 7'h6F);
    ok0(0);  rd(7'h00, 7'h3F);

    // bouncing units must not be accepted, the held pattern gives 21
    ok0(21);
    drive(0, 1'b1, 7'h5B, 6);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b0, 7'h06, 2);
      drive(0, 1'b0, 7'h07, 2);
    end
    drive(0, 1'b0, 7'h06, 6);

    // units timeout: tens held with no units
    err0(); drive(0, 1'b1, 7'h06, 72);
    ok0(45); rd(7'h66, 7'h6D);
    // blank units, tens 7 illegal, tens re-capture 2 -> 3
    err0(); rd(7'h06, 7'h00);
    err0(); drive(0, 1'b1, 7'h07, 6);
    ok0(30);
    drive(0, 1'b1, 7'h5B, 6);
    rd(7'h4F, 7'h3F);

    // reset in the middle of a read
    drive(0, 1'b1, 7'h5B, 6);
    rst_n = 1'b0;
    #1;
    chk("midreset valor", int'(valor0), 0);
    chk("midreset valido", int'(valido0), 0);
    chk("midreset erro", int'(erro0), 0);
    exp_valor0 = 0;
    exp_errs0 = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    drive(0, 1'b0, 7'h00, 2);
    ok0(34); rd(7'h4F, 7'h66);

    // active-low instance: 5 and 8 -> 58
    q1.push_back({1'b0, 6'd58}); exp_valor1 = 58;
    drive(1, 1'b1, ~7'h6D, 6);
    drive(1, 1'b0, ~7'h7F, 6);
    drive(1, 1'b0, ~7'h00, 2);
    chk("dut1 valor held", int'(valor1), int'(exp_valor1));

`ifdef LEITOR_DISPLAY_CONT_ERROS_EN
    err0(); drive(0, 1'b1, 7'h01, 6);
    err0(); drive(0, 1'b1, 7'h7F, 6);
    err0(); drive(0, 1'b1, 7'h55, 6);
    drive(0, 1'b0, 7'h00, 3);
    chk("cont_erros 3", int'(cont0), 3);
    for (int i = 0; i < 300; i++) begin
      err0(); drive(0, 1'b1, (i % 2) ? 7'h01 : 7'h55, 6);
    end
    drive(0, 1'b0, 7'h00, 3);
    chk("cont_erros saturated", int'(cont0), (exp_errs0 > 255) ? 255 : exp_errs0);
`endif

    drive(0, 1'b0, 7'h00, 10);
    chk("dut0 valor final", int'(valor0), int'(exp_valor0));
    chk("outstanding expectations", q0.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
